ahb_ssram_bridge: RTL and testbench

AHB_SSRAM_BRIDGE -- requirements
Module: ahb_ssram_bridge

---
 rtl/ahb_ssram_bridge.sv | 147 ++++++++++++++
 tb/tb_ahb_ssram_bridge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ssram_bridge.sv
// AHB-Lite slave to synchronous single-port SRAM bridge: zero-wait reads and writes, one stall on read-after-write.
// Optional macro AHB_SSRAM_RDATA_GATE_EN forces HRDATA to zero outside read data phases.
module ahb_ssram_bridge #(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          clk,
  input  logic          rst_n,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP,
  output logic [AW-1:0] ahb_sram_addr,
  output logic [3:0]    ahb_sram_enb,
  output logic [3:0]    ahb_sram_wb,
  output logic [31:0]   ahb_sram_din,
  output logic          ahb_sram_en,
  output logic          ahb_sram_we,
  input  logic [31:0]   sram_ahb_dout
);

  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << lsb;
      3'd1:    m = lsb[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // The legacy clock/reset pins are kept only for pin compatibility.
  logic unused_s;
  assign unused_s = ^{clk, rst_n};

  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]    wr_mask_q, wr_mask_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_dphase_q, rd_dphase_d;

  logic          accept_s;
  logic          acc_wr_s;
  logic          acc_rd_s;
  logic [AW-1:0] haddr_word_s;
  logic [AW-1:0] sram_addr_s;
  logic [3:0]    sram_enb_s;
  logic [3:0]    sram_wb_s;
  logic [31:0]   sram_din_s;

  // Address-phase decode and next-state of the pending write/read bookkeeping.
  always_comb begin
    accept_s     = HSEL & HREADY & HTRANS[1] & ~rd_pend_q;
    acc_wr_s     = accept_s & HWRITE;
    acc_rd_s     = accept_s & ~HWRITE;
    haddr_word_s = {2'b00, HADDR[AW-1:2]};

    wr_pend_d    = acc_wr_s;
    wr_addr_d    = wr_addr_q;
    wr_mask_d    = wr_mask_q;
    if (acc_wr_s) begin
      wr_addr_d = haddr_word_s;
      wr_mask_d = byte_mask(HSIZE, HADDR[1:0]);
    end else begin
      wr_addr_d = wr_addr_q;
      wr_mask_d = wr_mask_q;
    end

    // A read landing on a write data phase loses the SRAM port this cycle and is replayed next cycle.
    rd_pend_d = acc_rd_s & wr_pend_q;
    rd_addr_d = rd_addr_q;
    if (acc_rd_s && wr_pend_q) begin
      rd_addr_d = haddr_word_s;
    end else begin
      rd_addr_d = rd_addr_q;
    end
    rd_dphase_d = rd_pend_q | (acc_rd_s & ~wr_pend_q);
  end

  // SRAM port arbitration: write data phase first, then replayed read, then a fresh read.
  always_comb begin
    sram_addr_s = {AW{1'b0}};
    sram_enb_s  = 4'b0000;
    sram_wb_s   = 4'b0000;
    sram_din_s  = 32'h0000_0000;
    if (!HRESETn) begin
      sram_enb_s = 4'b0000;
    end else if (wr_pend_q) begin
      sram_addr_s = wr_addr_q;
      sram_enb_s  = wr_mask_q;
      sram_wb_s   = wr_mask_q;
      sram_din_s  = HWDATA;
    end else if (rd_pend_q) begin
      sram_addr_s = rd_addr_q;
      sram_enb_s  = 4'b1111;
    end else if (acc_rd_s) begin
      sram_addr_s = haddr_word_s;
      sram_enb_s  = 4'b1111;
    end else begin
      sram_enb_s = 4'b0000;
    end
  end

  // Transfer state registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= {AW{1'b0}};
      wr_mask_q   <= 4'b0000;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= {AW{1'b0}};
      rd_dphase_q <= 1'b0;
    end else begin
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_mask_q   <= wr_mask_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      rd_dphase_q <= rd_dphase_d;
    end
  end

  assign ahb_sram_addr = sram_addr_s;
  assign ahb_sram_enb  = sram_enb_s;
  assign ahb_sram_wb   = sram_wb_s;
  assign ahb_sram_din  = sram_din_s;
  assign ahb_sram_en   = |sram_enb_s;
  assign ahb_sram_we   = |sram_wb_s;

  assign HREADYOUT = ~rd_pend_q;
  assign HRESP     = 1'b0;

`ifdef AHB_SSRAM_RDATA_GATE_EN
  assign HRDATA = (rd_dphase_q & ~rd_pend_q) ? sram_ahb_dout : 32'h0000_0000;
`else
  assign HRDATA = sram_ahb_dout;
`endif

endmodule

// File: tb/tb_ahb_ssram_bridge.sv
// Bench for ahb_ssram_bridge: transaction-level reference model, SRAM behavioural model and per-cycle compare.
`timescale 1ns/1ps
module tb_ahb_ssram_bridge;
  localparam int AW = 12;
  localparam int NW = 1 << (AW - 2);
  localparam int P_NONE = 0, P_WR = 1, P_RD = 2, P_STALL = 3;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          clk, rst_n;
  logic          HSEL = 1'b0;
  logic [AW-1:0] HADDR = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd2;
  logic          HWRITE = 1'b0;
  logic [31:0]   HWDATA = 32'h0;
  logic          HREADY = 1'b1;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [AW-1:0] ahb_sram_addr;
  logic [3:0]    ahb_sram_enb, ahb_sram_wb;
  logic [31:0]   ahb_sram_din;
  logic          ahb_sram_en, ahb_sram_we;
  logic [31:0]   sram_dout = 32'h0;

  assign clk   = HCLK;
  assign rst_n = HRESETn;

  ahb_ssram_bridge #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .clk(clk), .rst_n(rst_n),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .ahb_sram_addr(ahb_sram_addr), .ahb_sram_enb(ahb_sram_enb), .ahb_sram_wb(ahb_sram_wb),
    .ahb_sram_din(ahb_sram_din), .ahb_sram_en(ahb_sram_en), .ahb_sram_we(ahb_sram_we),
    .sram_ahb_dout(sram_dout)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural synchronous SRAM: byte-lane writes, read data one cycle after an enabled read.
  logic [31:0] sram_mem [NW];
  always @(posedge HCLK) begin
    if (ahb_sram_en) begin
      if (ahb_sram_we) begin
        for (int l = 0; l < 4; l++)
          if (ahb_sram_wb[l]) sram_mem[ahb_sram_addr[AW-3:0]][8*l +: 8] <= ahb_sram_din[8*l +: 8];
      end else begin
        sram_dout <= sram_mem[ahb_sram_addr[AW-3:0]];
      end
    end
  end

  // Reference model state
  logic [31:0]   ref_mem [NW];
  int            pend_kind = P_NONE;
  logic [AW-1:0] pend_word;
  logic [3:0]    pend_mask;
  logic [31:0]   pend_data;

  // Expectations for the current cycle
  logic          chk_en = 1'b1;
  logic          exp_ready = 1'b1;
  logic [3:0]    exp_enb = 4'h0, exp_wb = 4'h0;
  logic [AW-1:0] exp_addr = '0;
  logic [31:0]   exp_din = 32'h0, exp_rdata = 32'h0;
  logic          exp_rd_valid = 1'b0;

  logic [31:0]   last_rdata = 32'h0;
  logic [3:0]    last_wb = 4'h0;
  int            lo_count = 0;
  int            n_cmp = 0, n_fail = 0;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model's expectations.
  always @(negedge HCLK) begin
    if (chk_en) begin
      cmp("hreadyout", 32'(HREADYOUT), 32'(exp_ready));
      cmp("hresp", 32'(HRESP), 32'h0);
      cmp("enb", 32'(ahb_sram_enb), 32'(exp_enb));
      cmp("wb", 32'(ahb_sram_wb), 32'(exp_wb));
      cmp("en", 32'(ahb_sram_en), 32'(|exp_enb));
      cmp("we", 32'(ahb_sram_we), 32'(|exp_wb));
      if (exp_enb != 4'h0) cmp("sram_addr", 32'(ahb_sram_addr), 32'(exp_addr));
      if (exp_wb != 4'h0) cmp("sram_din", ahb_sram_din, exp_din);
      if (exp_rd_valid) cmp("hrdata", HRDATA, exp_rdata);
`ifdef AHB_SSRAM_RDATA_GATE_EN
      if (!exp_rd_valid) cmp("hrdata_gated", HRDATA, 32'h0);
`else
      cmp("hrdata_pass", HRDATA, sram_dout);
`endif
    end
  end

  // Byte lanes touched by a transfer: 2**size bytes (capped at a word), aligned down inside the word.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [AW-1:0] addr);
    int nbytes;
    int first;
    nbytes = (size >= 3'd2) ? 4 : (1 << size);
    first  = int'(addr[1:0]) & ~(nbytes - 1);
    return 4'(((1 << nbytes) - 1) << first);
  endfunction

  task automatic set_idle_exp();
    exp_ready = 1'b1; exp_enb = 4'h0; exp_wb = 4'h0; exp_addr = '0;
    exp_din = 32'h0; exp_rd_valid = 1'b0; exp_rdata = 32'h0;
  endtask

  task automatic sample();
    @(negedge HCLK);
    if (exp_rd_valid) last_rdata = HRDATA;
    if (exp_wb != 4'h0) last_wb = ahb_sram_wb;
    if (HREADYOUT == 1'b0) lo_count++;
  endtask

  // Present one address phase (after any stall the model predicts), completing the previous data phase.
  task automatic present(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [AW-1:0] addr, input logic [31:0] wdata);
    bit was_wr;
    if (pend_kind == P_STALL) begin
      @(posedge HCLK); #1;
      HRESETn = 1'b1; HREADY = 1'b0;
      HSEL = 1'($urandom); HTRANS = 2'($urandom); HWRITE = 1'($urandom);
      HADDR = AW'($urandom); HWDATA = $urandom;
      set_idle_exp();
      exp_ready = 1'b0; exp_enb = 4'hF; exp_addr = pend_word;
      pend_kind = P_RD;
      sample();
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1; HREADY = 1'b1;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr; HWDATA = $urandom;
    set_idle_exp();
    was_wr = (pend_kind == P_WR);
    if (pend_kind == P_WR) begin
      HWDATA = pend_data;
      exp_enb = pend_mask; exp_wb = pend_mask; exp_addr = pend_word; exp_din = pend_data;
      for (int l = 0; l < 4; l++)
        if (pend_mask[l]) ref_mem[int'(pend_word)][8*l +: 8] = pend_data[8*l +: 8];
    end else if (pend_kind == P_RD) begin
      exp_rd_valid = 1'b1;
      exp_rdata = ref_mem[int'(pend_word)];
    end
    pend_kind = P_NONE;
    if (sel && trans[1]) begin
      pend_word = addr >> 2;
      if (wr) begin
        pend_kind = P_WR; pend_mask = lane_mask(size, addr); pend_data = wdata;
      end else if (was_wr) begin
        pend_kind = P_STALL;
      end else begin
        pend_kind = P_RD; exp_enb = 4'hF; exp_addr = addr >> 2;
      end
    end
    sample();
  endtask

  task automatic reset_cycles(input int n);
    repeat (n) begin
      @(posedge HCLK); #1;
      HRESETn = 1'b0; HREADY = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HSIZE = 3'd2;
      HWRITE = 1'($urandom); HADDR = AW'($urandom); HWDATA = $urandom;
      set_idle_exp();
      pend_kind = P_NONE;
      sample();
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [2:0] sz, input logic [31:0] d);
    present(1'b1, 2'b10, 1'b1, sz, a, d);
  endtask
  task automatic rd(input logic [AW-1:0] a);
    present(1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0);
  endtask
  task automatic idle();
    present(1'b0, 2'b00, 1'b0, 3'd2, '0, 32'h0);
  endtask

  initial begin
    logic          r_sel, r_wr;
    logic [1:0]    r_trans;
    logic [2:0]    r_size;
    logic [AW-1:0] r_addr;
    for (int i = 0; i < NW; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    reset_cycles(3);

    // Word writes, idle, two zero-wait reads
    wr(12'h010, 3'd2, 32'hCAFEBABE);
    wr(12'h014, 3'd2, 32'h12345678);
    idle(); idle(); idle();
    rd(12'h010);
    rd(12'h014);
    cmp("lit_rd_010", last_rdata, 32'hCAFEBABE);
    idle();
    cmp("lit_rd_014", last_rdata, 32'h12345678);

    // Byte write into lane 0
    wr(12'h010, 3'd0, 32'hAAAAAA55);
    rd(12'h010);
    idle();
    cmp("lit_byte_merge", last_rdata, 32'hCAFEBA55);

    // Halfword write to upper half over a zeroed word
    wr(12'h010, 3'd2, 32'h00000000);
    wr(12'h012, 3'd1, 32'hBEEF1234);
    idle();
    cmp("lit_half_wb", 32'(last_wb), 32'h0000000C);
    idle();
    rd(12'h010);
    idle();
    cmp("lit_half_rd", last_rdata, 32'hBEEF0000);

    // Read immediately after write: exactly one wait state
    idle();
    lo_count = 0;
    wr(12'h020, 3'd2, 32'hA5A5A5A5);
    rd(12'h020);
    idle();
    cmp("lit_raw_rd", last_rdata, 32'hA5A5A5A5);
    idle();
    cmp("lit_raw_waits", 32'(lo_count), 32'd1);

    // IDLE transfer and deselected write must not touch memory
    present(1'b1, 2'b00, 1'b1, 3'd2, 12'h020, 32'hFFFFFFFF);
    present(1'b0, 2'b10, 1'b1, 3'd2, 12'h020, 32'h00000000);
    idle();
    rd(12'h020);
    idle();
    cmp("lit_ignored_wr", last_rdata, 32'hA5A5A5A5);

    // Reset asserted during a write data phase aborts the write
    wr(12'h030, 3'd2, 32'h11112222);
    idle();
    wr(12'h030, 3'd2, 32'hDEADDEAD);
    reset_cycles(2);
    rd(12'h030);
    idle();
    cmp("lit_reset_abort", last_rdata, 32'h11112222);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r_sel   = ($urandom_range(0, 3) != 0);
      r_trans = 2'($urandom);
      r_wr    = 1'($urandom);
      r_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r_addr  = AW'($urandom_range(0, 127));
      if (r_size == 3'd1) r_addr[0] = 1'b0;
      else if (r_size >= 3'd2) r_addr[1:0] = 2'b00;
      present(r_sel, r_trans, r_wr, r_size, r_addr, $urandom);
      if ($urandom_range(0, 59) == 0) reset_cycles(1);
    end

    // Drain and read back the exercised region
    idle(); idle();
    for (int w = 0; w < 32; w++) rd(AW'(w * 4));
    idle(); idle();
    for (int w = 0; w < 64; w++) cmp("mem_final", sram_mem[w], ref_mem[w]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
